// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises the raw PS/2 pins into the system clock domain and debounces
// the PS/2 clock, producing a one-cycle pulse on each filtered falling edge.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic fall
);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  clk_filt_prev;

    // The idle level of both PS/2 lines is high, so everything resets to 1
    // to avoid a phantom falling edge when reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync      <= 2'b11;
            dat_sync      <= 2'b11;
            clk_hist      <= '1;
            clk_filt      <= 1'b1;
            clk_filt_prev <= 1'b1;
        end else begin
            // NOTE: every register here uses <= so all of them sample the
            // values from before this edge; blocking = would collapse the
            // two synchroniser stages into one.
            clk_sync      <= {clk_sync[0], ps2_clock};
            dat_sync      <= {dat_sync[0], ps2_data};
            clk_hist      <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            clk_filt_prev <= clk_filt;
            if (clk_hist == '0) begin
                clk_filt <= 1'b0;
            end else if (&clk_hist) begin
                clk_filt <= 1'b1;
            end
        end
    end

    assign data_sync = dat_sync[1];
    assign fall      = clk_filt_prev & ~clk_filt;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: start/8 data/odd parity/stop assembly with timeout.
// Optional feature macro PS2_RX_PREFIX_EN absorbs E0/F0 prefixes into is_ext/is_break.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
`ifdef PS2_RX_PREFIX_EN
    ,
    output logic       is_break,
    output logic       is_ext
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic             clk_filt;
    logic             data_sync;
    logic             fall;
    logic             edge_fall;

    ps2_state_t       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout;
    logic [7:0]       code_d;
    logic             valid_d, perr_d, ferr_d;
`ifdef PS2_RX_PREFIX_EN
    logic             ext_pend, ext_pend_d;
    logic             brk_pend, brk_pend_d;
    logic             is_ext_d, is_break_d;
`endif

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
        .clock     (clock),
        .reset     (reset),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .fall      (fall)
    );

    assign edge_fall = fall & ~clk_filt;
    assign timeout   = (state_q != IDLE) && !edge_fall && (to_cnt == TO_LAST);
    assign busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        code_d    = code;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef PS2_RX_PREFIX_EN
        ext_pend_d = ext_pend;
        brk_pend_d = brk_pend;
        is_ext_d   = 1'b0;
        is_break_d = 1'b0;
`endif
        if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end else if (edge_fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_sync) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shift_d   = {data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_sync;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_sync) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else begin
`ifdef PS2_RX_PREFIX_EN
                        if (shift_q == PS2_PREFIX_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_PREFIX_BRK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            valid_d    = 1'b1;
                            is_ext_d   = ext_pend;
                            is_break_d = brk_pend;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
`else
                        code_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef PS2_RX_PREFIX_EN
        if (ferr_d || perr_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            to_cnt     <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            to_cnt     <= (state_q == IDLE || edge_fall) ? '0 : to_cnt + 1'b1;
            code       <= code_d;
            code_valid <= valid_d;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
        end
    end

`ifdef PS2_RX_PREFIX_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            is_ext   <= 1'b0;
            is_break <= 1'b0;
        end else begin
            ext_pend <= ext_pend_d;
            brk_pend <= brk_pend_d;
            is_ext   <= is_ext_d;
            is_break <= is_break_d;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed frames plus randomized traffic,
// compared cycle-by-cycle against an event-level model of the receiver.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int TB_FILTER = 8;
    localparam int TB_TO     = 600;
    localparam int TB_TOW    = 10;
    // Pin edge to registered output: 2 sync + FILTER_LEN history + filter reg + output reg.
    localparam int LAT       = TB_FILTER + 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid, parity_err, frame_err, busy;
`ifdef PS2_RX_PREFIX_EN
    logic       is_break, is_ext;
`endif

    ps2_frame_rx #(.FILTER_LEN(TB_FILTER), .TIMEOUT_CYCLES(TB_TO), .TO_W(TB_TOW)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef PS2_RX_PREFIX_EN
        ,
        .is_break   (is_break),
        .is_ext     (is_ext)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        int         kind;   // 0 valid, 1 parity error, 2 frame error
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_code = 8'h00;
    logic       m_ext = 1'b0, m_brk = 1'b0;
    int         n_cmp = 0, n_bad = 0;
    int         n_valid = 0, n_perr = 0, n_ferr = 0;
    logic [7:0] last_code;
    logic       last_ext = 1'b0, last_brk = 1'b0;
    logic       cmp_en = 1'b0;
    logic       e_v, e_p, e_f, e_ext, e_brk;
    ev_t        cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: the fate of a completed frame follows from its stop and parity bits.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop, input int t);
        ev_t e;
        e.cycle = t; e.code = b; e.ext = 1'b0; e.brk = 1'b0;
        if (!stop) begin
            e.kind = 2; m_ext = 1'b0; m_brk = 1'b0; exp_q.push_back(e);
        end else if ((^b) == par) begin
            e.kind = 1; m_ext = 1'b0; m_brk = 1'b0; exp_q.push_back(e);
        end else begin
`ifdef PS2_RX_PREFIX_EN
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                e.kind = 0; e.ext = m_ext; e.brk = m_brk;
                m_ext = 1'b0; m_brk = 1'b0; exp_q.push_back(e);
            end
`else
            e.kind = 0; exp_q.push_back(e);
`endif
        end
    endtask

    task automatic model_end(input logic [10:0] bits, input int nbits, input int t);
        ev_t e;
        if (bits[0]) return;   // fall with data high in IDLE: ignored
        if (nbits < PS2_FRAME_BITS) begin
            e.cycle = t + TB_TO; e.kind = 2; e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0;
            m_ext = 1'b0; m_brk = 1'b0;
            exp_q.push_back(e);
        end else begin
            model_frame(bits[8:1], bits[9], bits[10], t);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] make_bits(input logic [7:0] b, input logic par_flip, input logic stop);
        return {stop, (~^b) ^ par_flip, b, 1'b0};
    endfunction

    task automatic drive_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(half);
            ps2_clock = 1'b0;
            if (i == nbits - 1) model_end(bits, nbits, cyc + LAT);
            tick(half);
            ps2_clock = 1'b1;
        end
        tick(half);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic par_flip, input logic stop);
        drive_bits(make_bits(b, par_flip, stop), PS2_FRAME_BITS, 25);
        tick(LAT);
    endtask

    task automatic glitch(input int width);
        ps2_clock = 1'b0;
        tick(width);
        ps2_clock = 1'b1;
        tick(20);
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            e_v = 1'b0; e_p = 1'b0; e_f = 1'b0; e_ext = 1'b0; e_brk = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
                cur = exp_q.pop_front();
                e_v = (cur.kind == 0); e_p = (cur.kind == 1); e_f = (cur.kind == 2);
                e_ext = cur.ext; e_brk = cur.brk;
                if (e_v) exp_code = cur.code;
            end
            check("code_valid", code_valid, e_v);
            check("parity_err", parity_err, e_p);
            check("frame_err", frame_err, e_f);
            check("code", code, exp_code);
`ifdef PS2_RX_PREFIX_EN
            if (e_v) begin
                check("is_ext", is_ext, e_ext);
                check("is_break", is_break, e_brk);
            end
`endif
            if (code_valid) begin
                n_valid++;
                last_code = code;
`ifdef PS2_RX_PREFIX_EN
                last_ext = is_ext;
                last_brk = is_break;
`endif
            end
            if (parity_err) n_perr++;
            if (frame_err) n_ferr++;
        end
    end

    int v0, p0, f0;

    task automatic snap();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    endtask

    initial begin
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
        reset     = 1'b1;
        tick(3);
        check("rst_code", code, 8'h00);
        check("rst_pulses", {code_valid, parity_err, frame_err}, 3'b000);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(2);
        cmp_en = 1'b1;

        // Good 0x1C frame
        snap();
        send(8'h1C, 1'b0, 1'b1);
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_err_cnt", (n_perr - p0) + (n_ferr - f0), 0);
        check("t1_code", code, 8'h1C);
        check("t1_busy", busy, 1'b0);

        // Same frame, parity flipped
        snap();
        send(8'h1C, 1'b1, 1'b1);
        check("t2_perr_cnt", n_perr - p0, 1);
        check("t2_valid_cnt", n_valid - v0, 0);
        check("t2_code", code, 8'h1C);

        // Bad stop bit, then clean 0x29
        snap();
        send(8'h29, 1'b0, 1'b0);
        check("t3_ferr_cnt", n_ferr - f0, 1);
        check("t3_perr_cnt", n_perr - p0, 0);
        send(8'h29, 1'b0, 1'b1);
        check("t3_code", code, 8'h29);

        // Five bits then silence: timeout
        snap();
        drive_bits(make_bits(8'h1C, 1'b0, 1'b1), 5, 25);
        check("t4_busy_mid", busy, 1'b1);
        tick(TB_TO + 10);
        check("t4_ferr_cnt", n_ferr - f0, 1);
        check("t4_busy_after", busy, 1'b0);
        send(8'h1C, 1'b0, 1'b1);
        check("t4_valid_cnt", n_valid - v0, 1);
        check("t4_code", code, 8'h1C);

        // IDLE noise: short glitch and a fall with data high
        snap();
        glitch(3);
        check("t5_busy_glitch", busy, 1'b0);
        drive_bits(11'h7FF, 1, 25);
        tick(LAT);
        check("t5_busy_fall", busy, 1'b0);
        check("t5_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int         kind, half;
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            half = $urandom_range(16, 32);
            if (kind == 2) glitch($urandom_range(1, TB_FILTER - 3));
            if (kind == 3) drive_bits(11'h7FF, 1, half);
            drive_bits(make_bits(b, kind == 0, kind != 1), PS2_FRAME_BITS, half);
            tick(LAT + $urandom_range(0, 10));
            check("rnd_busy", busy, 1'b0);
        end

`ifdef PS2_RX_PREFIX_EN
        snap();
        send(8'hF0, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        check("t6a_valid_cnt", n_valid - v0, 1);
        check("t6a_code", last_code, 8'h1C);
        check("t6a_brk", last_brk, 1'b1);
        check("t6a_ext", last_ext, 1'b0);
        snap();
        send(8'hE0, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b1);
        send(8'h75, 1'b0, 1'b1);
        check("t6b_valid_cnt", n_valid - v0, 1);
        check("t6b_code", last_code, 8'h75);
        check("t6b_ext", last_ext, 1'b1);
        check("t6b_brk", last_brk, 1'b1);
        // Prefix pending, reset mid-frame, then a plain byte
        send(8'hE0, 1'b0, 1'b1);
        snap();
        drive_bits(make_bits(8'h5A, 1'b0, 1'b1), 6, 25);
        reset = 1'b1;
        exp_q.delete();
        exp_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(5);
        check("t6c_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        check("t6c_busy", busy, 1'b0);
        send(8'h1C, 1'b0, 1'b1);
        check("t6c_code", last_code, 8'h1C);
        check("t6c_ext", last_ext, 1'b0);
        check("t6c_brk", last_brk, 1'b0);
`endif

        tick(TB_TO + LAT + 5);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
